// File: rtl/lau_pkg.sv
// Shared types and helpers for the Log-Mel audio front end:
// the squarer speed selector, the power-beat record and the saturating scaler.
package lau_pkg;

   typedef enum logic {
      FAST  = 1'b0,
      SMALL = 1'b1
   } speed_t;

   localparam logic [3:0] POW_SHIFT_DEFAULT = 4'd0;

   localparam int POW_OW = 24;
   localparam int POW_BW = 9;

   typedef struct packed {
      logic [POW_OW-1:0] power;
      logic              sat;
      logic              last;
      logic [POW_BW-1:0] bin;
   } power_beat_t;

   // Logical right shift, then clip to ow bits. Result is {sat, power},
   // with power zero-extended to 64 bits.
   function automatic logic [64:0] sat_shift(input logic [63:0] sum,
                                             input logic [7:0]  sh,
                                             input int          ow);
      logic [63:0] t;
      logic [63:0] hi_mask;
      t       = sum >> sh;
      hi_mask = ~64'd0 << ow;
      if ((t & hi_mask) != 64'd0) begin
         return {1'b1, ~hi_mask};
      end
      return {1'b0, t};
   endfunction

endpackage

// File: rtl/SqrSgn.sv
// Combinational square of a signed value; the result is unsigned and 2*W bits wide.
// SPEED selects a direct signed multiply or a magnitude-only multiply.
module SqrSgn
   import lau_pkg::*;
#(
   parameter int     W     = 18,
   parameter speed_t SPEED = FAST
) (
   input  logic signed [W-1:0]   din,
   output logic        [2*W-1:0] sq
);

   generate
      if (SPEED == FAST) begin : g_fast
         logic signed [2*W-1:0] ext;
         logic signed [2*W-1:0] prod;
         assign ext  = {{W{din[W-1]}}, din};
         assign prod = ext * ext;
         assign sq   = $unsigned(prod);
      end else begin : g_small
         // -(-2^(W-1)) wraps to the same bit pattern, which is the correct magnitude unsigned.
         logic [W-1:0]   mag;
         logic [2*W-1:0] mag_ext;
         assign mag     = din[W-1] ? $unsigned(-din) : $unsigned(din);
         assign mag_ext = {{W{1'b0}}, mag};
         assign sq      = mag_ext * mag_ext;
      end
   endgenerate

endmodule

// File: rtl/power_calc_pipe.sv
// Two-stage pipelined STFT-bin power (re^2 + im^2) with per-beat scale shift,
// output saturation, ready/valid backpressure and frame-position checking.
module power_calc_pipe
   import lau_pkg::*;
#(
   parameter int     IW    = 18,
   parameter int     OW    = 24,
   parameter int     SW    = 4,
   parameter int     NBINS = 257,
   parameter speed_t SPEED = FAST
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [IW-1:0]     real_il,
   input  logic signed [IW-1:0]     imag_il,
   input  logic                     last_il,
   input  logic                     valid_il,
   output logic                     ready_ol,
   input  logic [SW-1:0]            shift_il,
   output logic [OW-1:0]            power_ol,
   output logic                     sat_ol,
   output logic                     last_ol,
   output logic [$clog2(NBINS)-1:0] bin_ol,
   output logic                     valid_ol,
   input  logic                     ready_il,
   output logic                     frame_err_ol
);

   localparam int              BW       = $clog2(NBINS);
   localparam int              SQW      = 2 * IW;
   localparam logic [BW-1:0]   BIN_LAST = BW'(NBINS - 1);

   // Handshake: a beat moves on a clock edge where valid and ready are both high.
   // ready_ol depends only on valid_ol and ready_il; the whole pipe advances or holds together.
   logic en;
   logic accept;
   assign en       = !valid_ol || ready_il;
   assign ready_ol = en;
   assign accept   = valid_il && en;

   logic [SQW-1:0] re_sq_c, im_sq_c;

   SqrSgn #(.W(IW), .SPEED(SPEED)) u_sqr_re (.din(real_il), .sq(re_sq_c));
   SqrSgn #(.W(IW), .SPEED(SPEED)) u_sqr_im (.din(imag_il), .sq(im_sq_c));

   // Bin position; wraps on last or at the final bin so a misaligned frame re-syncs on the next last.
   logic [BW-1:0] bin_cnt;
   logic          at_last_bin;
   assign at_last_bin = (bin_cnt == BIN_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_cnt      <= '0;
         frame_err_ol <= 1'b0;
      end else if (accept) begin
         bin_cnt <= (last_il || at_last_bin) ? '0 : bin_cnt + 1'b1;
         if (last_il != at_last_bin) begin
            frame_err_ol <= 1'b1;
         end
      end
   end

   logic           s1_valid;
   logic [SQW-1:0] s1_re_sq, s1_im_sq;
   logic [SW-1:0]  s1_shift;
   logic           s1_last;
   logic [BW-1:0]  s1_bin;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_re_sq <= '0;
         s1_im_sq <= '0;
         s1_shift <= '0;
         s1_last  <= 1'b0;
         s1_bin   <= '0;
      end else if (en) begin
         s1_valid <= accept;
         if (accept) begin
            s1_re_sq <= re_sq_c;
            s1_im_sq <= im_sq_c;
            s1_shift <= shift_il;
            s1_last  <= last_il;
            s1_bin   <= bin_cnt;
         end
      end
   end

   // One guard bit holds the worst case 2 * 2^(2*IW-2) = 2^(2*IW-1).
   logic [SQW:0]  sum;
   logic [63:0]   pw_full;
   logic          sat_c;
   logic          unused_hi;
   assign sum                = {1'b0, s1_re_sq} + {1'b0, s1_im_sq};
   assign {sat_c, pw_full}   = sat_shift(64'(sum), 8'(s1_shift), OW);
   assign unused_hi          = |pw_full[63:OW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_ol <= 1'b0;
         power_ol <= '0;
         sat_ol   <= 1'b0;
         last_ol  <= 1'b0;
         bin_ol   <= '0;
      end else if (en) begin
         valid_ol <= s1_valid;
         if (s1_valid) begin
            power_ol <= pw_full[OW-1:0];
            sat_ol   <= sat_c;
            last_ol  <= s1_last;
            bin_ol   <= s1_bin;
         end
      end
   end

endmodule

// File: tb/tb_power_calc_pipe.sv
// Bench for power_calc_pipe: vector table plus directed stall, shift, frame and reset sequences,
// all results checked against an expected-beat queue.
module tb_power_calc_pipe;
   import lau_pkg::*;

   localparam int IW    = 18;
   localparam int OW    = 24;
   localparam int SW    = 4;
   localparam int NBINS = 257;
   localparam int BW    = 9;
   localparam int EW    = OW + 1 + 1 + BW;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic signed [IW-1:0] real_il = '0;
   logic signed [IW-1:0] imag_il = '0;
   logic                 last_il = 1'b0;
   logic                 valid_il = 1'b0;
   logic                 ready_ol;
   logic [SW-1:0]        shift_il = '0;
   logic [OW-1:0]        power_ol;
   logic                 sat_ol;
   logic                 last_ol;
   logic [BW-1:0]        bin_ol;
   logic                 valid_ol;
   logic                 ready_il = 1'b1;
   logic                 frame_err_ol;

   power_calc_pipe #(.IW(IW), .OW(OW), .SW(SW), .NBINS(NBINS), .SPEED(FAST)) dut (
      .clk(clk), .rst_n(rst_n),
      .real_il(real_il), .imag_il(imag_il), .last_il(last_il),
      .valid_il(valid_il), .ready_ol(ready_ol), .shift_il(shift_il),
      .power_ol(power_ol), .sat_ol(sat_ol), .last_ol(last_ol), .bin_ol(bin_ol),
      .valid_ol(valid_ol), .ready_il(ready_il), .frame_err_ol(frame_err_ol)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int             checks = 0;
   int             errors = 0;
   logic [EW-1:0]  exp_q[$];
   int             exp_bin = 0;
   logic           exp_ferr = 1'b0;
   logic           stall_prev = 1'b0;
   logic [EW-1:0]  held;
   int             stall_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference power: integer arithmetic on the full-precision sum, clipped against the OW-bit maximum.
   function automatic logic [OW:0] model_pow(input int re, input int im, input int sh);
      longint sum;
      longint t;
      sum = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      t   = sum >> sh;
      if (t > longint'(24'hFFFFFF)) return {1'b1, {OW{1'b1}}};
      return {1'b0, t[OW-1:0]};
   endfunction

   // Called at posedge+#1; returns at posedge+#1 after the capturing edge.
   task automatic send_beat(input int re, input int im, input int sh, input logic last,
                            input logic [OW:0] exp_ps);
      logic accepted;
      accepted = 1'b0;
      real_il  = IW'(re);
      imag_il  = IW'(im);
      shift_il = SW'(sh);
      last_il  = last;
      valid_il = 1'b1;
      for (int w = 0; w < 400; w++) begin
         @(negedge clk);
         if (ready_ol) begin
            accepted = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!accepted) begin
         check("accept_timeout", 64'd0, 64'd1);
      end else begin
         exp_q.push_back({exp_ps[OW-1:0], exp_ps[OW], last, BW'(exp_bin)});
         if (last != (exp_bin == NBINS - 1)) exp_ferr = 1'b1;
         exp_bin = (last || exp_bin == NBINS - 1) ? 0 : exp_bin + 1;
      end
      @(posedge clk);
      #1;
      valid_il = 1'b0;
      last_il  = 1'b0;
   endtask

   task automatic drain();
      for (int w = 0; w < 500; w++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      valid_il = 1'b0;
      ready_il = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      exp_bin  = 0;
      exp_ferr = 1'b0;
   endtask

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_hold", 64'({power_ol, sat_ol, last_ol, bin_ol}), 64'(held));
            check("stall_valid", 64'(valid_ol), 64'd1);
         end
         if (valid_ol && !ready_il) begin
            check("ready_in_stall", 64'(ready_ol), 64'd0);
            stall_cnt++;
         end
         if (valid_ol && ready_il) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 64'({power_ol, sat_ol, last_ol, bin_ol}), 64'd0);
            end else begin
               logic [EW-1:0] e;
               e = exp_q.pop_front();
               check("beat", 64'({power_ol, sat_ol, last_ol, bin_ol}), 64'(e));
            end
         end
         stall_prev = valid_ol && !ready_il;
         held       = {power_ol, sat_ol, last_ol, bin_ol};
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      int            re;
      int            im;
      int            sh;
      logic [OW-1:0] pw;
      logic          sat;
   } vec_t;

   vec_t tbl[12];
   logic done_rand = 1'b0;

   initial begin
      tbl[0]  = '{3,       4,       0,  24'd25,       1'b0};
      tbl[1]  = '{-131072, -131072, 6,  24'hFFFFFF,   1'b1};
      tbl[2]  = '{-131072, -131072, 12, 24'h800000,   1'b0};
      tbl[3]  = '{0,       0,       15, 24'd0,        1'b0};
      tbl[4]  = '{-1,      1,       0,  24'd2,        1'b0};
      tbl[5]  = '{4095,    0,       0,  24'd16769025, 1'b0};
      tbl[6]  = '{4096,    0,       0,  24'hFFFFFF,   1'b1};
      tbl[7]  = '{4096,    0,       1,  24'h800000,   1'b0};
      tbl[8]  = '{131071,  131071,  15, 24'd1048560,  1'b0};
      tbl[9]  = '{-131072, 0,       15, 24'd524288,   1'b0};
      tbl[10] = '{131071,  -131072, 13, 24'd4194272,  1'b0};
      tbl[11] = '{2896,    2896,    0,  24'd16773632, 1'b0};

      do_reset();
      check("rst_valid", 64'(valid_ol), 64'd0);
      check("rst_power", 64'(power_ol), 64'd0);
      check("rst_sat", 64'(sat_ol), 64'd0);
      check("rst_last", 64'(last_ol), 64'd0);
      check("rst_bin", 64'(bin_ol), 64'd0);
      check("rst_ferr", 64'(frame_err_ol), 64'd0);
      check("rst_ready", 64'(ready_ol), 64'd1);

      // Two-cycle latency: output register loads on the second edge after the beat is presented.
      send_beat(3, 4, 0, 1'b0, model_pow(3, 4, 0));
      check("latency_s1", 64'(valid_ol), 64'd0);
      @(posedge clk);
      #1;
      check("latency_out", 64'(valid_ol), 64'd1);
      check("latency_power", 64'(power_ol), 64'd25);
      drain();

      for (int i = 0; i < 12; i++) begin
         send_beat(tbl[i].re, tbl[i].im, tbl[i].sh, 1'b0, {tbl[i].sat, tbl[i].pw});
      end
      drain();

      // Ten beats with the downstream stalled for four cycles.
      stall_cnt = 0;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               send_beat(i * 100 + 1, -i * 7, i % 16, 1'b0, model_pow(i * 100 + 1, -i * 7, i % 16));
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            ready_il = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            ready_il = 1'b1;
         end
      join
      drain();
      check("stall_observed", 64'(stall_cnt >= 3), 64'd1);

      for (int s = 0; s < 16; s++) begin
         send_beat(-131072, 131071, s, 1'b0, model_pow(-131072, 131071, s));
      end
      drain();

      // Random data and shifts against random downstream readiness.
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               int re, im, sh;
               re = int'($urandom_range(0, 262143)) - 131072;
               im = int'($urandom_range(0, 262143)) - 131072;
               sh = int'($urandom_range(0, 15));
               send_beat(re, im, sh, 1'b0, model_pow(re, im, sh));
            end
            done_rand = 1'b1;
         end
         begin
            while (!done_rand) begin
               @(posedge clk);
               #1;
               ready_il = ($urandom_range(0, 3) != 0);
            end
         end
      join
      ready_il = 1'b1;
      drain();
      check("ferr_clean", 64'(frame_err_ol), 64'(exp_ferr));

      // Well-formed frame, then a frame with last at bin 100.
      do_reset();
      for (int i = 0; i < NBINS; i++) begin
         send_beat(i, -i, 0, (i == NBINS - 1), model_pow(i, -i, 0));
      end
      drain();
      check("ferr_good_frame", 64'(frame_err_ol), 64'd0);
      for (int i = 0; i <= 100; i++) begin
         send_beat(i + 7, 3, 1, (i == 100), model_pow(i + 7, 3, 1));
      end
      send_beat(9, 9, 0, 1'b0, model_pow(9, 9, 0));
      drain();
      check("ferr_short_frame", 64'(frame_err_ol), 64'd1);
      check("ferr_model", 64'(frame_err_ol), 64'(exp_ferr));

      // Asynchronous reset with two beats in flight.
      send_beat(1000, 1000, 0, 1'b0, model_pow(1000, 1000, 0));
      send_beat(2000, 5, 0, 1'b0, model_pow(2000, 5, 0));
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(valid_ol), 64'd0);
      check("arst_power", 64'(power_ol), 64'd0);
      check("arst_sat", 64'(sat_ol), 64'd0);
      check("arst_last", 64'(last_ol), 64'd0);
      check("arst_bin", 64'(bin_ol), 64'd0);
      check("arst_ferr", 64'(frame_err_ol), 64'd0);
      exp_q.delete();
      exp_bin  = 0;
      exp_ferr = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_beat(5, 12, 0, 1'b0, model_pow(5, 12, 0));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
